// File: rtl/id_ex_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_ctrl_if
//   Bundle of the hazard-controller signals exchanged with the pipeline.
//   master : pipeline side. Drives the ID/EX hazard inputs and stat_clr, and
//            receives the enables, flushes, status and stall_count.
//   slave  : controller side (id_ex_hazard_ctrl).
//   Signals:
//     id_rs, id_rt, id_uses_rt     source specifiers of the ID instruction
//     ex_rt, ex_mem_read           destination / load flag of the EX instruction
//     ex_branch_taken, ex_md_start branch and mult/div status of EX
//     stat_clr                     synchronous clear of stall_count
//     pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush
//     md_busy, md_done, stall_count
// ---------------------------------------------------------------------------
interface id_ex_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  ex_md_start;
    logic                  stat_clr;

    logic                  pc_write;
    logic                  if_id_write;
    logic                  if_id_flush;
    logic                  id_ex_write;
    logic                  id_ex_flush;
    logic                  md_busy;
    logic                  md_done;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read,
               ex_branch_taken, ex_md_start, stat_clr,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               md_busy, md_done, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read,
               ex_branch_taken, ex_md_start, stat_clr,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               md_busy, md_done, stall_count
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// id_ex_hazard_ctrl
//   Sequencing controller for PC, IF/ID and ID/EX. Resolves, in priority
//   order: mult/div freeze, taken-branch flush, load-use bubble. Keeps a
//   saturating count of PC-stall cycles.
//   Ports:
//     clk      pipeline clock, rising edge
//     reset_n  asynchronous active-low reset
//     hz       id_ex_hazard_ctrl_if.slave, all hazard inputs and controls
//   The enables and flushes are combinational; md_busy reflects the FSM
//   state directly (high exactly while in MD_BUSY).
// ---------------------------------------------------------------------------
module id_ex_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_CYCLES  = 4,
    parameter int CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    id_ex_hazard_ctrl_if.slave   hz
);
    localparam int CNT_BITS = $clog2(MD_CYCLES);
    localparam logic [CNT_BITS-1:0] MD_LAST = CNT_BITS'(MD_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

    typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic                load_use;

    // Register 0 is hard-wired zero, so a load targeting it never hazards.
    assign load_use = hz.ex_mem_read && (hz.ex_rt != '0) &&
                      ((hz.ex_rt == hz.id_rs) ||
                       (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hz.pc_write    = 1'b1;
        hz.if_id_write = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_write = 1'b1;
        hz.id_ex_flush = 1'b0;
        hz.md_done     = 1'b0;
        // While reset is held the outputs stay at their idle values
        // regardless of the (possibly garbage) hazard inputs.
        if (reset_n) begin
            unique case (state_q)
                RUN: begin
                    if (hz.ex_md_start) begin
                        hz.pc_write    = 1'b0;
                        hz.if_id_write = 1'b0;
                        hz.id_ex_write = 1'b0;
                        state_d        = MD_BUSY;
                        cnt_d          = MD_LAST;
                    end else if (hz.ex_branch_taken) begin
                        hz.if_id_flush = 1'b1;
                        hz.id_ex_flush = 1'b1;
                    end else if (load_use) begin
                        hz.pc_write    = 1'b0;
                        hz.if_id_write = 1'b0;
                        hz.id_ex_flush = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (cnt_q > CNT_ONE) begin
                        hz.pc_write    = 1'b0;
                        hz.if_id_write = 1'b0;
                        hz.id_ex_write = 1'b0;
                        cnt_d          = cnt_q - CNT_ONE;
                    end else begin
                        // Final EX cycle: op completes, pipeline may move.
                        // Branches are not honoured here; load-use still is.
                        hz.md_done = 1'b1;
                        state_d    = RUN;
                        cnt_d      = '0;
                        if (load_use) begin
                            hz.pc_write    = 1'b0;
                            hz.if_id_write = 1'b0;
                            hz.id_ex_flush = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.stat_clr) begin
            stall_cnt_d = '0;
        end else if (!hz.pc_write && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.md_busy     = (state_q == MD_BUSY);
    assign hz.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
module tb_id_ex_hazard_ctrl;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    id_ex_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) hif ();

    id_ex_hazard_ctrl #(.REG_ADDR_W(5), .MD_CYCLES(4), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hif)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, md_busy, md_done}
    logic [6:0] outs;
    assign outs = {hif.pc_write, hif.if_id_write, hif.if_id_flush,
                   hif.id_ex_write, hif.id_ex_flush, hif.md_busy, hif.md_done};

    localparam logic [6:0] O_IDLE    = 7'b1101000;
    localparam logic [6:0] O_LOADUSE = 7'b0001100;
    localparam logic [6:0] O_BRANCH  = 7'b1111100;
    localparam logic [6:0] O_FRZ_RUN = 7'b0000000;
    localparam logic [6:0] O_FRZ_MD  = 7'b0000010;
    localparam logic [6:0] O_MD_DONE = 7'b1101011;
    localparam logic [6:0] O_MD_LU   = 7'b0001111;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic idle_inputs();
        hif.id_rs           = '0;
        hif.id_rt           = '0;
        hif.id_uses_rt      = 1'b0;
        hif.ex_rt           = '0;
        hif.ex_mem_read     = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.ex_md_start     = 1'b0;
        hif.stat_clr        = 1'b0;
    endtask

    // advance one edge; inputs are changed and outputs sampled 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL reset_outs: got %b expected %b", outs, O_IDLE);
        end
        checks++;
        if (hif.stall_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", hif.stall_count);
        end
        reset_n = 1'b1;
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL idle_outs: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_load_use();
        // rs match
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd5;
        hif.id_rs       = 5'd5;
        settle();
        checks++;
        if (outs !== O_LOADUSE) begin
            errors++;
            $display("FAIL lu_rs_outs: got %b expected %b", outs, O_LOADUSE);
        end
        step();
        idle_inputs();
        settle();
        checks++;
        if (hif.stall_count !== 16'd1) begin
            errors++;
            $display("FAIL lu_rs_count: got %0d expected 1", hif.stall_count);
        end
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL lu_one_bubble: got %b expected %b", outs, O_IDLE);
        end
        // rt match with id_uses_rt
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd9;
        hif.id_rt       = 5'd9;
        hif.id_rs       = 5'd3;
        hif.id_uses_rt  = 1'b1;
        settle();
        checks++;
        if (outs !== O_LOADUSE) begin
            errors++;
            $display("FAIL lu_rt_outs: got %b expected %b", outs, O_LOADUSE);
        end
        step();
        idle_inputs();
        settle();
        checks++;
        if (hif.stall_count !== 16'd2) begin
            errors++;
            $display("FAIL lu_rt_count: got %0d expected 2", hif.stall_count);
        end
    endtask

    task automatic test_load_use_neg();
        // destination r0
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd0;
        hif.id_rs       = 5'd0;
        settle();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL lu_r0_outs: got %b expected %b", outs, O_IDLE);
        end
        step();
        // rt match but rt not a source
        hif.ex_rt      = 5'd7;
        hif.id_rt      = 5'd7;
        hif.id_rs      = 5'd3;
        hif.id_uses_rt = 1'b0;
        settle();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL lu_rt_unused_outs: got %b expected %b", outs, O_IDLE);
        end
        // non-load with matching rs
        hif.ex_mem_read = 1'b0;
        hif.id_rs       = 5'd7;
        settle();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL lu_noload_outs: got %b expected %b", outs, O_IDLE);
        end
        step();
        idle_inputs();
        settle();
        checks++;
        if (hif.stall_count !== 16'd2) begin
            errors++;
            $display("FAIL lu_neg_count: got %0d expected 2", hif.stall_count);
        end
    endtask

    task automatic test_branch();
        hif.ex_branch_taken = 1'b1;
        settle();
        checks++;
        if (outs !== O_BRANCH) begin
            errors++;
            $display("FAIL branch_outs: got %b expected %b", outs, O_BRANCH);
        end
        // branch outranks a simultaneous load-use
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd4;
        hif.id_rs       = 5'd4;
        settle();
        checks++;
        if (outs !== O_BRANCH) begin
            errors++;
            $display("FAIL branch_over_lu: got %b expected %b", outs, O_BRANCH);
        end
        step();
        idle_inputs();
        settle();
        checks++;
        if (hif.stall_count !== 16'd2) begin
            errors++;
            $display("FAIL branch_count: got %0d expected 2", hif.stall_count);
        end
    endtask

    task automatic test_md();
        hif.stat_clr = 1'b1;
        step();
        hif.stat_clr = 1'b0;
        settle();
        checks++;
        if (hif.stall_count !== 16'd0) begin
            errors++;
            $display("FAIL clr_count: got %0d expected 0", hif.stall_count);
        end
        // cycle 1: RUN, start seen
        hif.ex_md_start = 1'b1;
        settle();
        checks++;
        if (outs !== O_FRZ_RUN) begin
            errors++;
            $display("FAIL md_c1: got %b expected %b", outs, O_FRZ_RUN);
        end
        step();
        // cycle 2: branch is ignored in MD_BUSY
        hif.ex_branch_taken = 1'b1;
        settle();
        checks++;
        if (outs !== O_FRZ_MD) begin
            errors++;
            $display("FAIL md_c2_branch: got %b expected %b", outs, O_FRZ_MD);
        end
        step();
        hif.ex_branch_taken = 1'b0;
        settle();
        checks++;
        if (outs !== O_FRZ_MD) begin
            errors++;
            $display("FAIL md_c3: got %b expected %b", outs, O_FRZ_MD);
        end
        step();
        // cycle 4: done; start still high and a branch, both ignored
        hif.ex_branch_taken = 1'b1;
        settle();
        checks++;
        if (outs !== O_MD_DONE) begin
            errors++;
            $display("FAIL md_c4_done: got %b expected %b", outs, O_MD_DONE);
        end
        step();
        idle_inputs();
        settle();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL md_exit: got %b expected %b", outs, O_IDLE);
        end
        checks++;
        if (hif.stall_count !== 16'd3) begin
            errors++;
            $display("FAIL md_count: got %0d expected 3", hif.stall_count);
        end
    endtask

    task automatic test_back_to_back();
        hif.ex_md_start = 1'b1;
        step();
        step();
        step();
        // last MD cycle with a load-use pending
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd12;
        hif.id_rs       = 5'd12;
        settle();
        checks++;
        if (outs !== O_MD_LU) begin
            errors++;
            $display("FAIL md_last_lu: got %b expected %b", outs, O_MD_LU);
        end
        step();
        // new op right after exit
        hif.ex_mem_read = 1'b0;
        settle();
        checks++;
        if (outs !== O_FRZ_RUN) begin
            errors++;
            $display("FAIL b2b_start: got %b expected %b", outs, O_FRZ_RUN);
        end
        checks++;
        if (hif.stall_count !== 16'd7) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 7", hif.stall_count);
        end
        step();
        settle();
        checks++;
        if (outs !== O_FRZ_MD) begin
            errors++;
            $display("FAIL b2b_busy: got %b expected %b", outs, O_FRZ_MD);
        end
    endtask

    task automatic test_md_reset();
        // still in MD_BUSY from the previous task
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL md_reset_outs: got %b expected %b", outs, O_IDLE);
        end
        checks++;
        if (hif.stall_count !== 16'd0) begin
            errors++;
            $display("FAIL md_reset_count: got %0d expected 0", hif.stall_count);
        end
        idle_inputs();
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (outs !== O_IDLE) begin
            errors++;
            $display("FAIL post_reset_outs: got %b expected %b", outs, O_IDLE);
        end
    endtask

    task automatic test_saturation();
        hif.ex_mem_read = 1'b1;
        hif.ex_rt       = 5'd2;
        hif.id_rs       = 5'd2;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk);
        end
        #1;
        checks++;
        if (hif.stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_count: got %h expected ffff", hif.stall_count);
        end
        hif.stat_clr = 1'b1;
        step();
        checks++;
        if (hif.stall_count !== 16'd0) begin
            errors++;
            $display("FAIL clr_over_inc: got %h expected 0000", hif.stall_count);
        end
        hif.stat_clr = 1'b0;
        step();
        checks++;
        if (hif.stall_count !== 16'd1) begin
            errors++;
            $display("FAIL inc_after_clr: got %h expected 0001", hif.stall_count);
        end
        idle_inputs();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_load_use_neg();
        test_branch();
        test_md();
        test_back_to_back();
        test_md_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Pipeline sequencing controller for the ID/EX register and the stages around it.
- Generates PC, IF/ID and ID/EX write enables and flush (bubble) controls.
- Stall and flush causes:
  - load-use hazards,
  - taken branches resolved in EX,
  - multi-cycle multiply/divide ops that must occupy EX for several cycles.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- REG_ADDR_W, 5, register-specifier width.
- MD_CYCLES, 4, total cycles a mult/div op occupies EX. Legal range is 2 or more.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_rt  in  REG_ADDR_W  destination of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- ex_md_start  in  1  EX holds a mult/div op.
- stat_clr  in  1  synchronous clear of stall_count.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_write  out  1  ID/EX load enable.
- id_ex_flush  out  1  ID/EX loads a bubble (all zeros).
- md_busy  out  1  mult/div sequencing in progress.
- md_done  out  1  one-cycle pulse in the final EX cycle of a mult/div op.
- stall_count  out  CNT_W  PC-stall cycles since reset or clear.

Behaviour:
- State: FSM {RUN, MD_BUSY}, down-counter cnt (width clog2(MD_CYCLES)), stall_count register.
- Reset: reset_n low forces, asynchronously:
  - state=RUN, cnt=0, stall_count=0;
  - pc_write=if_id_write=id_ex_write=1;
  - if_id_flush=id_ex_flush=md_busy=md_done=0.
- Default (no hazard): all write enables 1, both flushes 0.
- Enable and flush outputs are combinational from the current state and inputs.
- Priority 1, freeze:
  - freeze = (RUN and ex_md_start) or (MD_BUSY and cnt>1).
  - Effect: pc_write=if_id_write=id_ex_write=0, both flushes 0. Every stage holds.
- Priority 2, branch (RUN only, no freeze):
  - Condition: ex_branch_taken=1.
  - Effect: if_id_flush=1, id_ex_flush=1, pc_write=1.
  - ex_branch_taken is ignored in MD_BUSY.
- Priority 3, load-use:
  - Condition: ex_mem_read=1, ex_rt!=0, and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
  - Effect: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1. Inserts exactly one bubble.
  - Evaluated in RUN and in the non-frozen last MD_BUSY cycle.
- FSM transitions:
  - RUN with ex_md_start=1 -> MD_BUSY; cnt loads MD_CYCLES-1.
  - MD_BUSY: cnt decrements each edge. When cnt==1: md_done=1, freeze released, next edge -> RUN.
- Timing:
  - The mult/div op occupies EX for exactly MD_CYCLES cycles.
  - The upstream stall is MD_CYCLES-1 cycles.
  - ex_md_start is ignored in MD_BUSY.
  - A new mult/div op may start in the first RUN cycle after exit.
- md_busy = 1 iff state==MD_BUSY.
- stall_count:
  - Increments at each edge where pc_write==0.
  - Saturates at all-ones.
  - stat_clr=1 zeroes it at the edge and takes priority over increment.
- Reset mid-MD_BUSY: immediate return to RUN, all outputs at reset values, no md_done pulse.

Test Plan:
- Reset, then idle inputs -> pc_write=if_id_write=id_ex_write=1, flushes 0, stall_count=0.
- Load-use, rs match: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 for that cycle; stall_count=1 after the edge.
- Load-use negatives:
  - ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall.
  - id_rt=7=ex_rt with id_uses_rt=0 -> no stall.
- Taken branch: ex_branch_taken=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1 for one cycle; stall_count unchanged.
- Mult/div, MD_CYCLES=4: ex_md_start held 1 until EX advances ->
  - freeze for 3 cycles;
  - md_busy high for 3 cycles;
  - md_done pulse on the 4th cycle with write enables back to 1;
  - stall_count=3.
  - Also: ex_branch_taken=1 mid-BUSY -> no flush.
  - Also: reset_n low mid-BUSY -> md_busy=0 immediately.
- Counter saturation/clear: force stalls past 0xFFFF -> stays 0xFFFF. stat_clr=1 together with a stall -> 0 after the edge.
